// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- types and constants shared by the memory arbiter files.
//   arb_state_e  : arbiter FSM state encoding
//   ADDR_W_DEF   : default address width
//   DATA_W_DEF   : default data width
//   TIMEOUT_DATA : read data returned when a transfer is aborted by timeout
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout -- watchdog counter for one memory transfer.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   clr     : clear the count (asserted when a new transfer is granted)
//   en      : count this cycle (busy and no memory completion)
//   expire  : the current counting cycle is the TIMEOUT-th without completion
module mem_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Combinational so the FSM leaves BUSY on the very cycle the count
  // reaches TIMEOUT; no extra cycle is spent observing the terminal value.
  assign expire = en && (cnt_reg == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates an instruction-fetch port and a data port onto
// one shared memory port, one transfer at a time.
// Ports:
//   clk_i, rst_i                       : clock / async active-low reset
//   if_req_i, if_addr_i                : fetch read request (held until ack)
//   if_rdata_o, if_ack_o               : fetch read data / 1-cycle completion
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                         : data access request (held until ack)
//   dm_rdata_o, dm_ack_o               : data read data / 1-cycle completion
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                        : shared memory command
//   mem_rdata_i, mem_ack_i             : shared memory response
//   stall_o                            : pipeline stall (pending requests)
//   err_o                              : sticky timeout flag
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; undefined gives fixed priority (data port wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_e        state_reg, state_next;
  logic              owner_dm_reg;        // 1: current transfer belongs to dm
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] dm_rdata_reg;
  logic              err_reg;

  logic busy;
  logic any_req;
  logic grant_dm;
  logic grant;
  logic finish;
  logic expire;

  assign busy    = (state_reg == BUSY_IF) || (state_reg == BUSY_DM);
  assign any_req = if_req_i | dm_req_i;
  assign grant   = (state_reg == IDLE) && any_req;
  assign finish  = busy && (mem_ack_i || expire);

`ifdef MEM_ARB_RR_EN
  // 1: dm received the most recent grant. Reset value 0 means "IF last",
  // so the first contention goes to dm.
  logic last_dm_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_dm_reg <= 1'b0;
    end else if (grant) begin
      last_dm_reg <= grant_dm;
    end
  end

  assign grant_dm = dm_req_i & (~if_req_i | ~last_dm_reg);
`else
  assign grant_dm = dm_req_i;
`endif

  mem_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (grant),
    .en    (busy & ~mem_ack_i),
    .expire(expire)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = grant_dm ? BUSY_DM : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack_i || expire) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, read-data capture and error flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_dm_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (grant) begin
        owner_dm_reg  <= grant_dm;
        mem_we_reg    <= grant_dm & dm_we_i;
        mem_addr_reg  <= grant_dm ? dm_addr_i : if_addr_i;
        mem_wdata_reg <= grant_dm ? dm_wdata_i : '0;
      end
      if (finish) begin
        // Write enable is only meaningful while the command is on the bus.
        mem_we_reg <= 1'b0;
        if (!mem_we_reg) begin
          if (owner_dm_reg) begin
            dm_rdata_reg <= mem_ack_i ? mem_rdata_i : DATA_W'(TIMEOUT_DATA);
          end else begin
            if_rdata_reg <= mem_ack_i ? mem_rdata_i : DATA_W'(TIMEOUT_DATA);
          end
        end
        if (!mem_ack_i) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign dm_rdata_o  = dm_rdata_reg;
  assign if_ack_o    = (state_reg == DONE) && !owner_dm_reg;
  assign dm_ack_o    = (state_reg == DONE) && owner_dm_reg;
  assign err_o       = err_reg;
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
// A second instance with TIMEOUT=4 shares all inputs and is only examined
// in the timeout scenario (after a common reset).
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, err_o;

  logic [31:0] t_if_rdata, t_dm_rdata, t_mem_addr, t_mem_wdata;
  logic        t_if_ack, t_dm_ack, t_mem_req, t_mem_we, t_stall, t_err;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_to (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(t_if_rdata), .if_ack_o(t_if_ack),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(t_dm_rdata), .dm_ack_o(t_dm_ack),
    .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr),
    .mem_wdata_o(t_mem_wdata), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(t_stall), .err_o(t_err)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp;
    @(negedge clk_i);
  endtask

  // Entered just after the edge that starts the first BUSY cycle. Acks the
  // memory after lat extra BUSY cycles; returns just after the edge into DONE.
  task automatic serve(input int lat, input logic [31:0] rd, input logic [31:0] addr,
                       input logic we, input logic [31:0] wdata, input logic stall);
    for (int i = 0; i <= lat; i++) begin
      if (i == lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
      end
      smp;
      chk1("busy_mem_req", mem_req_o, 1'b1);
      chk32("busy_mem_addr", mem_addr_o, addr);
      chk1("busy_mem_we", mem_we_o, we);
      if (we) chk32("busy_mem_wdata", mem_wdata_o, wdata);
      chk1("busy_stall", stall_o, stall);
      chk1("busy_no_ack", if_ack_o | dm_ack_o, 1'b0);
      cyc;
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
  endtask

  // Called at the sample point of the DONE cycle: pops the scoreboard.
  task automatic check_done;
    exp_t e;
    chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk1("done_if_ack", if_ack_o, !e.is_dm);
      chk1("done_dm_ack", dm_ack_o, e.is_dm);
      chk1("done_mem_req", mem_req_o, 1'b0);
      if (e.is_dm) begin
        chk32("done_dm_rdata", dm_rdata_o, e.rdata);
        chk32("done_if_rdata_kept", if_rdata_o, last_if);
        last_dm = e.rdata;
      end else begin
        chk32("done_if_rdata", if_rdata_o, e.rdata);
        chk32("done_dm_rdata_kept", dm_rdata_o, last_dm);
        last_if = e.rdata;
      end
      $display("txn %s rdata=%h if_ack=%b dm_ack=%b", e.is_dm ? "dm" : "if",
               e.is_dm ? dm_rdata_o : if_rdata_o, if_ack_o, dm_ack_o);
    end
  endtask

  // Both requesters raise a read together; first_dm says who must win.
  task automatic contend(input logic first_dm, input logic [31:0] a_if, input logic [31:0] a_dm);
    if_req_i  = 1'b1;
    if_addr_i = a_if;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = a_dm;
    exp_q.push_back('{first_dm, 32'h1111_1111});
    exp_q.push_back('{!first_dm, 32'h2222_2222});
    smp;
    chk1("ct_stall", stall_o, 1'b1);
    cyc;
    serve(1, 32'h1111_1111, first_dm ? a_dm : a_if, 1'b0, '0, 1'b1);
    smp;
    check_done;
    chk1("ct_stall_other", stall_o, 1'b1);
    cyc;
    if (first_dm) dm_req_i = 1'b0;
    else          if_req_i = 1'b0;
    smp;
    chk1("ct_gap_req", mem_req_o, 1'b0);
    cyc;
    serve(2, 32'h2222_2222, first_dm ? a_if : a_dm, 1'b0, '0, 1'b1);
    smp;
    check_done;
    cyc;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
  endtask

  initial begin
    logic rr_first_dm;
`ifdef MEM_ARB_RR_EN
    rr_first_dm = 1'b0;   // dm won the previous grant, so if wins now
`else
    rr_first_dm = 1'b1;   // fixed priority: dm always wins
`endif

    // Reset state
    repeat (3) cyc;
    smp;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_mem_we", mem_we_o, 1'b0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    chk1("rst_acks", if_ack_o | dm_ack_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk32("rst_if_rdata", if_rdata_o, 32'h0);
    chk32("rst_dm_rdata", dm_rdata_o, 32'h0);
    cyc;
    rst_i = 1'b1;
    cyc;

    // Fetch read at minimum latency: ack two cycles after the request
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0040;
    exp_q.push_back('{1'b0, 32'h1234_5678});
    smp;
    chk1("t1_idle_req", mem_req_o, 1'b0);
    chk1("t1_stall", stall_o, 1'b1);
    cyc;
    serve(0, 32'h1234_5678, 32'h0000_0040, 1'b0, '0, 1'b1);
    smp;
    check_done;
    chk1("t1_done_stall", stall_o, 1'b0);
    cyc;
    if_req_i = 1'b0;

    // Data read to give dm_rdata a known value
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h0000_0080;
    exp_q.push_back('{1'b1, 32'hAAAA_5555});
    cyc;
    serve(0, 32'hAAAA_5555, 32'h0000_0080, 1'b0, '0, 1'b1);
    smp;
    check_done;
    cyc;
    dm_req_i = 1'b0;

    // Data write, memory latency 5: we held 6 cycles, rdata untouched
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h0000_0100;
    dm_wdata_i = 32'hCAFE_0001;
    exp_q.push_back('{1'b1, 32'hAAAA_5555});
    smp;
    chk1("t2_stall", stall_o, 1'b1);
    cyc;
    serve(5, 32'h5555_0000, 32'h0000_0100, 1'b1, 32'hCAFE_0001, 1'b1);
    smp;
    check_done;
    chk1("t2_we_dropped", mem_we_o, 1'b0);
    cyc;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_wdata_i = '0;

    // Contention right after a dm grant
    contend(rr_first_dm, 32'h0000_0200, 32'h0000_0300);

    // Fetch request dropped during BUSY still completes
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0044;
    exp_q.push_back('{1'b0, 32'h4444_4444});
    cyc;
    if_req_i = 1'b0;
    serve(2, 32'h4444_4444, 32'h0000_0044, 1'b0, '0, 1'b0);
    smp;
    check_done;
    chk1("t4_stall", stall_o, 1'b0);
    cyc;

    // Contention right after an if grant: dm wins in both modes
    contend(1'b1, 32'h0000_0208, 32'h0000_0308);

    // Stray memory ack while idle is ignored
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    smp;
    chk1("t5_idle_req", mem_req_o, 1'b0);
    cyc;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    smp;
    chk1("t5_no_ack", if_ack_o | dm_ack_o, 1'b0);
    chk32("t5_if_rdata", if_rdata_o, last_if);
    chk32("t5_dm_rdata", dm_rdata_o, last_dm);
    chk1("t5_err", err_o, 1'b0);
    chk1("t5_sb_empty", exp_q.size() == 0, 1'b1);
    $display("txn idle_stray_ack if_ack=%b dm_ack=%b", if_ack_o, dm_ack_o);

    // Common reset before the timeout scenario
    cyc;
    rst_i = 1'b0;
    cyc;
    rst_i = 1'b1;
    smp;
    chk1("t6_rst_err_to", t_err, 1'b0);
    chk1("t6_rst_req_to", t_mem_req, 1'b0);
    cyc;

    // Timeout (TIMEOUT=4 instance): no memory ack at all
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h0000_0400;
    cyc;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk1("to_busy_req", t_mem_req, 1'b1);
      chk1("to_busy_ack", t_dm_ack, 1'b0);
      chk1("to_busy_err", t_err, 1'b0);
      cyc;
    end
    smp;
    chk1("to_ack", t_dm_ack, 1'b1);
    chk32("to_rdata", t_dm_rdata, 32'hDEAD_BEEF);
    chk1("to_err", t_err, 1'b1);
    chk1("to_req_low", t_mem_req, 1'b0);
    chk1("main_still_busy", mem_req_o, 1'b1);
    chk1("main_no_ack", dm_ack_o, 1'b0);
    $display("txn dm timeout rdata=%h err=%b", t_dm_rdata, t_err);
    cyc;
    dm_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk1("to_err_sticky", t_err, 1'b1);
      chk1("to_idle_req", t_mem_req, 1'b0);
      chk1("main_busy_dm", mem_req_o, 1'b1);
      chk1("main_err", err_o, 1'b0);
      chk1("main_stall", stall_o, 1'b0);
      cyc;
    end

    // Asynchronous reset in the middle of a BUSY_DM cycle
    #2;
    rst_i = 1'b0;
    #1;
    chk1("ar_mem_req", mem_req_o, 1'b0);
    chk1("ar_dm_ack", dm_ack_o, 1'b0);
    chk32("ar_dm_rdata", dm_rdata_o, 32'h0);
    chk1("ar_err_to", t_err, 1'b0);
    $display("txn async_reset mem_req=%b dm_ack=%b", mem_req_o, dm_ack_o);
    smp;
    chk1("ar_hold_req", mem_req_o, 1'b0);
    cyc;
    rst_i       = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    smp;
    chk1("ar_stray_ack", dm_ack_o | if_ack_o, 1'b0);
    chk1("ar_stray_req", mem_req_o, 1'b0);
    cyc;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    smp;
    chk1("ar_post_ack", dm_ack_o | if_ack_o, 1'b0);
    chk32("ar_post_dm_rdata", dm_rdata_o, 32'h0);
    chk32("ar_post_if_rdata", if_rdata_o, 32'h0);
    $display("txn stray_ack_after_reset dm_ack=%b", dm_ack_o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
